// File: rtl/touch_sample_scheduler.sv
// Touchpad frame scheduler: Z conversions each PERIOD, then X/Y if pressure passes Z_THRESH, each axis averaged.
// sample_valid follows the last response by 2 cycles; cmd_valid/cmd hold while the SPI engine stalls cmd_ready.
module touch_sample_scheduler #(
  parameter int unsigned PERIOD   = 250000,
  parameter int unsigned AVG_LOG2 = 3,
  parameter int unsigned TIMEOUT  = 4096,
  parameter logic [11:0] Z_THRESH = 12'h080,
  parameter logic [7:0]  CMD_X    = 8'hD3,
  parameter logic [7:0]  CMD_Y    = 8'h93,
  parameter logic [7:0]  CMD_Z    = 8'hB3
) (
  input  logic        cclk,
  input  logic        rst,
  input  logic        enable,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd,
  input  logic        rsp_valid,
  input  logic [11:0] rsp_data,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic [11:0] z,
  output logic        pen_down,
  output logic        sample_valid,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun
);

  localparam int unsigned ACC_W = 12 + AVG_LOG2;
  localparam int unsigned N_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned CNT_W = $clog2(PERIOD);
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [N_W-1:0]   N_LAST   = N_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_AXDONE, S_PUBLISH} state_t;
  typedef enum logic [1:0] {AX_Z, AX_X, AX_Y} axis_t;

  state_t           state;
  axis_t            axis;
  logic [CNT_W-1:0] period_cnt;
  logic [TMR_W-1:0] timer;
  logic [N_W-1:0]   n;
  logic [ACC_W-1:0] acc;
  logic             tick;
  logic [11:0]      avg;

  assign tick = (period_cnt == CNT_LAST);
  assign avg  = acc[ACC_W-1:AVG_LOG2];

  always_ff @(posedge cclk) begin
    if (rst) begin
      state        <= S_IDLE;
      axis         <= AX_Z;
      period_cnt   <= '0;
      timer        <= '0;
      n            <= '0;
      acc          <= '0;
      cmd_valid    <= 1'b0;
      cmd          <= '0;
      x            <= '0;
      y            <= '0;
      z            <= '0;
      pen_down     <= 1'b0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      period_cnt   <= tick ? '0 : period_cnt + 1'b1;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
      // A tick that lands on a running frame is dropped, not queued.
      overrun      <= tick && (state != S_IDLE);

      case (state)
        S_IDLE: begin
          if (tick && enable) begin
            state     <= S_ISSUE;
            axis      <= AX_Z;
            acc       <= '0;
            n         <= '0;
            cmd       <= CMD_Z;
            cmd_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end

        S_ISSUE: begin
          if (cmd_ready) begin
            state     <= S_WAIT;
            timer     <= '0;
            cmd_valid <= 1'b0;
          end
        end

        S_WAIT: begin
          // A response arriving on the last timer cycle still counts.
          if (rsp_valid) begin
            acc <= acc + ACC_W'(rsp_data);
            if (n == N_LAST) begin
              state <= S_AXDONE;
            end else begin
              n         <= n + 1'b1;
              state     <= S_ISSUE;
              cmd_valid <= 1'b1;
            end
          end else if (timer == TMR_LAST) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_AXDONE: begin
          acc <= '0;
          n   <= '0;
          case (axis)
            AX_Z: begin
              z <= avg;
              if (avg >= Z_THRESH) begin
                axis      <= AX_X;
                cmd       <= CMD_X;
                cmd_valid <= 1'b1;
                state     <= S_ISSUE;
              end else begin
                pen_down     <= 1'b0;
                sample_valid <= 1'b1;
                state        <= S_PUBLISH;
              end
            end
            AX_X: begin
              x         <= avg;
              axis      <= AX_Y;
              cmd       <= CMD_Y;
              cmd_valid <= 1'b1;
              state     <= S_ISSUE;
            end
            default: begin
              y            <= avg;
              pen_down     <= 1'b1;
              sample_valid <= 1'b1;
              state        <= S_PUBLISH;
            end
          endcase
        end

        S_PUBLISH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_touch_sample_scheduler.sv
// Directed bench for touch_sample_scheduler with a small SPI engine model that answers after eng_delay cycles.
module tb_touch_sample_scheduler;

  logic        cclk;
  logic        rst;
  logic        enable;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd;
  logic        rsp_valid;
  logic [11:0] rsp_data;
  logic [11:0] x, y, z;
  logic        pen_down;
  logic        sample_valid;
  logic        busy;
  logic        timeout_err;
  logic        overrun;

  touch_sample_scheduler #(
    .PERIOD  (64),
    .AVG_LOG2(2),
    .TIMEOUT (32)
  ) dut (
    .cclk        (cclk),
    .rst         (rst),
    .enable      (enable),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd         (cmd),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .x           (x),
    .y           (y),
    .z           (z),
    .pen_down    (pen_down),
    .sample_valid(sample_valid),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Engine configuration, written by the main sequence.
  int          eng_delay = 3;
  bit          eng_respond = 1'b1;
  logic [11:0] zv[4];
  logic [11:0] xv[4];
  logic [11:0] yv[4];

  // Engine/monitor state, written only by the engine process.
  int          cyc = 0;
  int          n_cmd = 0, n_samp = 0, n_tmo = 0, n_ovr = 0;
  int          hs_cyc = 0, rsp_cyc = 0, samp_cyc = 0, tmo_cyc = 0;
  logic [7:0]  cmd_log[$];

  initial begin
    cclk = 1'b0;
    forever #5 cclk = ~cclk;
  end

  initial forever begin
    @(posedge cclk);
    cyc = cyc + 1;
  end

  // Engine model: observes the handshake in the cycle it occurs and presents
  // rsp_valid for the one cycle eng_delay cycles later.
  initial begin
    bit          pend;
    int          due;
    int          zi, xi, yi;
    logic [11:0] pend_data;
    pend = 1'b0; due = 0; zi = 0; xi = 0; yi = 0; pend_data = '0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    forever begin
      @(negedge cclk);
      rsp_valid = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else if (pend && cyc >= due) begin
        rsp_valid = 1'b1;
        rsp_data  = pend_data;
        pend      = 1'b0;
        rsp_cyc   = cyc;
      end
      if (!rst && cmd_valid && cmd_ready) begin
        cmd_log.push_back(cmd);
        n_cmd  = n_cmd + 1;
        hs_cyc = cyc;
        if (eng_respond) begin
          pend = 1'b1;
          due  = cyc + eng_delay;
          case (cmd)
            8'hD3:   begin pend_data = xv[xi % 4]; xi++; end
            8'h93:   begin pend_data = yv[yi % 4]; yi++; end
            default: begin pend_data = zv[zi % 4]; zi++; end
          endcase
        end
      end
      if (sample_valid) begin n_samp = n_samp + 1; samp_cyc = cyc; end
      if (timeout_err)  begin n_tmo = n_tmo + 1; tmo_cyc = cyc; end
      if (overrun)      n_ovr = n_ovr + 1;
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge cclk);
    #1;
  endtask

  task automatic wait_samp(input int base, input int budget, output bit got);
    int i;
    i = 0;
    while (n_samp == base && i < budget) begin step(1); i++; end
    got = (n_samp != base);
  endtask

  task automatic wait_tmo(input int base, input int budget, output bit got);
    int i;
    i = 0;
    while (n_tmo == base && i < budget) begin step(1); i++; end
    got = (n_tmo != base);
  endtask

  task automatic wait_cmd_valid(input int budget, output bit got);
    int i;
    i = 0;
    while (cmd_valid !== 1'b1 && i < budget) begin step(1); i++; end
    got = (cmd_valid === 1'b1);
  endtask

  task automatic wait_busy(input int budget, output bit got);
    int i;
    i = 0;
    while (busy !== 1'b1 && i < budget) begin step(1); i++; end
    got = (busy === 1'b1);
  endtask

  task automatic test_reset();
    step(4);
    n_checks++;
    if ({cmd_valid, busy, sample_valid, timeout_err, overrun, pen_down} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {cmd_valid, busy, sample_valid, timeout_err, overrun, pen_down});
    end
    n_checks++;
    if (cmd !== 8'h00) begin n_errors++; $display("FAIL reset_cmd: got %h expected 00", cmd); end
    n_checks++;
    if ({x, y, z} !== 36'h0) begin
      n_errors++;
      $display("FAIL reset_xyz: got x=%h y=%h z=%h expected 000", x, y, z);
    end
    // Release with enable low: ticks pass but nothing starts.
    rst = 1'b0;
    step(140);
    n_checks++;
    if (n_cmd !== 0 || busy !== 1'b0 || n_ovr !== 0) begin
      n_errors++;
      $display("FAIL enable_low_idle: got cmds=%0d busy=%b overruns=%0d expected 0 0 0", n_cmd, busy, n_ovr);
    end
  endtask

  task automatic test_reset_mid_issue();
    bit got;
    enable    = 1'b1;
    cmd_ready = 1'b0;
    wait_cmd_valid(100, got);
    n_checks++;
    if (!got) begin n_errors++; $display("FAIL mid_issue_start: got no cmd_valid expected cmd_valid=1"); end
    rst = 1'b1;
    step(1);
    n_checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_issue_reset: got cmd_valid=%b busy=%b expected 0 0", cmd_valid, busy);
    end
    step(2);
    rst = 1'b0;
    step(1);
    n_checks++;
    if ({cmd_valid, busy, sample_valid, pen_down, x, y, z} !== 40'h0) begin
      n_errors++;
      $display("FAIL mid_issue_outputs: got cv=%b busy=%b sv=%b pd=%b x=%h y=%h z=%h expected all 0",
               cmd_valid, busy, sample_valid, pen_down, x, y, z);
    end
    n_checks++;
    if (n_samp !== 0 || n_cmd !== 0) begin
      n_errors++;
      $display("FAIL mid_issue_partial: got samples=%0d cmds=%0d expected 0 0", n_samp, n_cmd);
    end
  endtask

  task automatic test_pen_up();
    int c0, s0;
    bit got;
    for (int i = 0; i < 4; i++) zv[i] = 12'h010;
    cmd_ready = 1'b1;
    c0 = n_cmd; s0 = n_samp;
    wait_samp(s0, 200, got);
    n_checks++;
    if (!got) begin n_errors++; $display("FAIL pen_up_sample: got no sample_valid expected one"); end
    n_checks++;
    if (n_cmd - c0 !== 4) begin n_errors++; $display("FAIL pen_up_cmd_count: got %0d expected 4", n_cmd - c0); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (cmd_log[c0 + i] !== 8'hB3) begin
        n_errors++;
        $display("FAIL pen_up_cmd[%0d]: got %h expected b3", i, cmd_log[c0 + i]);
      end
    end
    n_checks++;
    if (z !== 12'h010 || pen_down !== 1'b0 || x !== 12'h000 || y !== 12'h000) begin
      n_errors++;
      $display("FAIL pen_up_result: got z=%h pd=%b x=%h y=%h expected 010 0 000 000", z, pen_down, x, y);
    end
    n_checks++;
    if (samp_cyc - rsp_cyc !== 2) begin
      n_errors++;
      $display("FAIL pen_up_latency: got %0d expected 2", samp_cyc - rsp_cyc);
    end
    step(3);
    n_checks++;
    if (n_samp - s0 !== 1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL pen_up_pulse: got pulses=%0d busy=%b expected 1 0", n_samp - s0, busy);
    end
  endtask

  task automatic test_pen_down();
    int c0, s0;
    bit got;
    logic [7:0] exp_cmd;
    for (int i = 0; i < 4; i++) begin
      zv[i] = 12'h100;
      xv[i] = 12'h100 + 12'(2 * i);
      yv[i] = 12'h200;
    end
    c0 = n_cmd; s0 = n_samp;
    wait_samp(s0, 250, got);
    n_checks++;
    if (!got) begin n_errors++; $display("FAIL pen_down_sample: got no sample_valid expected one"); end
    n_checks++;
    if (n_cmd - c0 !== 12) begin n_errors++; $display("FAIL pen_down_cmd_count: got %0d expected 12", n_cmd - c0); end
    for (int i = 0; i < 12; i++) begin
      exp_cmd = (i < 4) ? 8'hB3 : (i < 8) ? 8'hD3 : 8'h93;
      n_checks++;
      if (c0 + i >= cmd_log.size() || cmd_log[c0 + i] !== exp_cmd) begin
        n_errors++;
        $display("FAIL pen_down_cmd[%0d]: got %h expected %h", i,
                 (c0 + i < cmd_log.size()) ? cmd_log[c0 + i] : 8'hxx, exp_cmd);
      end
    end
    n_checks++;
    if (z !== 12'h100 || x !== 12'h103 || y !== 12'h200 || pen_down !== 1'b1) begin
      n_errors++;
      $display("FAIL pen_down_result: got z=%h x=%h y=%h pd=%b expected 100 103 200 1", z, x, y, pen_down);
    end
    n_checks++;
    if (samp_cyc - rsp_cyc !== 2) begin
      n_errors++;
      $display("FAIL pen_down_latency: got %0d expected 2", samp_cyc - rsp_cyc);
    end
  endtask

  task automatic test_backpressure();
    int c0, s0;
    bit got;
    for (int i = 0; i < 4; i++) zv[i] = 12'h010;
    cmd_ready = 1'b0;
    c0 = n_cmd; s0 = n_samp;
    wait_cmd_valid(100, got);
    n_checks++;
    if (!got) begin n_errors++; $display("FAIL bp_start: got no cmd_valid expected cmd_valid=1"); end
    for (int i = 0; i < 5; i++) begin
      step(1);
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd !== 8'hB3 || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: got cv=%b cmd=%h busy=%b expected 1 b3 1", i, cmd_valid, cmd, busy);
      end
    end
    n_checks++;
    if (n_cmd !== c0) begin n_errors++; $display("FAIL bp_no_accept: got %0d cmds expected 0", n_cmd - c0); end
    cmd_ready = 1'b1;
    wait_samp(s0, 200, got);
    n_checks++;
    if (!got || n_cmd - c0 !== 4) begin
      n_errors++;
      $display("FAIL bp_frame: got sample=%b cmds=%0d expected 1 4", got, n_cmd - c0);
    end
    n_checks++;
    if (z !== 12'h010 || pen_down !== 1'b0 || x !== 12'h103 || y !== 12'h200) begin
      n_errors++;
      $display("FAIL bp_result: got z=%h pd=%b x=%h y=%h expected 010 0 103 200", z, pen_down, x, y);
    end
  endtask

  task automatic test_timeout();
    int c0, s0, t0;
    bit got;
    eng_respond = 1'b0;
    c0 = n_cmd; s0 = n_samp; t0 = n_tmo;
    wait_tmo(t0, 200, got);
    eng_respond = 1'b1;
    n_checks++;
    if (!got) begin n_errors++; $display("FAIL timeout_pulse: got none expected one"); end
    // hs_cyc is the cycle the handshake is presented; the edge closing it starts the 32 WAIT cycles.
    n_checks++;
    if (tmo_cyc - hs_cyc !== 33) begin
      n_errors++;
      $display("FAIL timeout_delay: got %0d expected 33", tmo_cyc - hs_cyc);
    end
    n_checks++;
    if (busy !== 1'b0 || n_tmo - t0 !== 1) begin
      n_errors++;
      $display("FAIL timeout_idle: got busy=%b pulses=%0d expected 0 1", busy, n_tmo - t0);
    end
    n_checks++;
    if (n_samp !== s0 || n_cmd - c0 !== 1) begin
      n_errors++;
      $display("FAIL timeout_abort: got samples=%0d cmds=%0d expected 0 1", n_samp - s0, n_cmd - c0);
    end
    n_checks++;
    if (z !== 12'h010 || pen_down !== 1'b0 || x !== 12'h103 || y !== 12'h200) begin
      n_errors++;
      $display("FAIL timeout_hold: got z=%h pd=%b x=%h y=%h expected 010 0 103 200", z, pen_down, x, y);
    end
  endtask

  task automatic test_overrun();
    int c0, s0, o0;
    bit got;
    // 20-cycle replies stay inside the WAIT limit yet stretch the frame past one period.
    eng_delay = 20;
    c0 = n_cmd; s0 = n_samp; o0 = n_ovr;
    wait_samp(s0, 300, got);
    eng_delay = 3;
    n_checks++;
    if (!got) begin n_errors++; $display("FAIL overrun_sample: got none expected one"); end
    n_checks++;
    if (n_ovr - o0 !== 1) begin n_errors++; $display("FAIL overrun_pulse: got %0d expected 1", n_ovr - o0); end
    n_checks++;
    if (n_cmd - c0 !== 4 || z !== 12'h010) begin
      n_errors++;
      $display("FAIL overrun_frame: got cmds=%0d z=%h expected 4 010", n_cmd - c0, z);
    end
  endtask

  task automatic test_enable_off();
    int c0, s0, o0;
    bit got;
    c0 = n_cmd; s0 = n_samp;
    wait_busy(100, got);
    enable = 1'b0;
    n_checks++;
    if (!got) begin n_errors++; $display("FAIL enable_frame_start: got busy=0 expected 1"); end
    wait_samp(s0, 100, got);
    n_checks++;
    if (!got || n_cmd - c0 !== 4) begin
      n_errors++;
      $display("FAIL enable_frame_done: got sample=%b cmds=%0d expected 1 4", got, n_cmd - c0);
    end
    c0 = n_cmd; s0 = n_samp; o0 = n_ovr;
    step(200);
    n_checks++;
    if (n_cmd !== c0 || n_samp !== s0 || n_ovr !== o0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL enable_blocked: got cmds=%0d samples=%0d overruns=%0d busy=%b expected 0 0 0 0",
               n_cmd - c0, n_samp - s0, n_ovr - o0, busy);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin zv[i] = '0; xv[i] = '0; yv[i] = '0; end
    test_reset();
    test_reset_mid_issue();
    test_pen_up();
    test_pen_down();
    test_backpressure();
    test_timeout();
    test_overrun();
    test_enable_off();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
